// File: rtl/synaptic_decay_bank.sv
// synaptic_decay_bank
//   N-channel synaptic current decay/integrate bank for the Izhikevich neuron
//   pipeline. During a timestep each channel accumulates incoming spike
//   currents in acc[c]. A step request walks all channels once through a single
//   shared multiplier:
//     cur[c] <= sat(floor(cur[c] * decay / 2^FRAC) + acc[c]);  acc[c] <= 0
//   Every sum saturates to the signed W-bit range and never wraps.
//
// Build option
//   DECAY_PER_CH_EN : replaces the global decay port with per-channel decay
//                     registers written through cfg_en/cfg_ch/cfg_decay.
//                     These registers reset to 1.0.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   wr_en/wr_ch/  add wr_data into acc[wr_ch] (saturating). A wr_ch value of
//   wr_data       NCH or above is ignored.
//   step_req      start one timestep update (pulse or level)
//   decay         global unsigned Q(W-FRAC).FRAC decay (default build only)
//   cfg_en/cfg_ch/cfg_decay  per-channel decay write (DECAY_PER_CH_EN only)
//   busy          high while channels are being processed
//   done          one-cycle pulse after the last channel has been written
//   step_overrun  sticky; step_req seen while a step was still in flight
//   i_out         cur[c] packed at bits [c*W +: W]
module synaptic_decay_bank #(
  parameter int NCH  = 4,
  parameter int W    = 16,
  parameter int FRAC = 15,
  parameter int CW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_ch,
  input  logic [W-1:0]      wr_data,
  input  logic              step_req,
`ifdef DECAY_PER_CH_EN
  input  logic              cfg_en,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [W-1:0]      cfg_decay,
`else
  input  logic [W-1:0]      decay,
`endif
  output logic              busy,
  output logic              done,
  output logic              step_overrun,
  output logic [NCH*W-1:0]  i_out
);

  // The wide sum width leaves generous headroom for the saturation check.
  localparam int SW = 2*W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] ch;

  logic [NCH-1:0][W-1:0] acc_vec;
  logic [NCH-1:0][W-1:0] cur_vec;
`ifdef DECAY_PER_CH_EN
  logic [NCH-1:0][W-1:0] dec_vec;
  localparam logic [W-1:0] DEC_ONE = W'(1 << FRAC);
`endif

  // This function clamps a wide signed value to the signed W-bit range.
  // The value fits when every bit from W-1 upward equals the sign bit.
  function automatic logic [W-1:0] sat_w(input logic signed [SW-1:0] v);
    if (v[SW-1:W-1] == {(W+3){v[SW-1]}})
      return v[W-1:0];
    else if (v[SW-1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

  // --------------------------------------------------------------------------
  // Shared update datapath: it operates on the channel selected by ch.
  // --------------------------------------------------------------------------
  logic [W-1:0]          cur_sel;
  logic [W-1:0]          acc_sel;
  logic [W-1:0]          dec_sel;
  logic signed [2*W:0]   cur_ext;
  logic signed [2*W:0]   dec_ext;
  logic signed [2*W:0]   prod;
  logic signed [2*W:0]   prod_shift;
  logic signed [SW-1:0]  upd_sum;
  logic [W-1:0]          upd_val;

  always_comb begin
    cur_sel = '0;
    acc_sel = '0;
    dec_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == CW'(i)) begin
        cur_sel = cur_vec[i];
        acc_sel = acc_vec[i];
`ifdef DECAY_PER_CH_EN
        dec_sel = dec_vec[i];
`endif
      end
    end
`ifndef DECAY_PER_CH_EN
    dec_sel = decay;
`endif
  end

  // Treat cur as signed and decay as unsigned.
  // The exact product always fits in 2W+1 bits.
  assign cur_ext    = {{(W+1){cur_sel[W-1]}}, cur_sel};
  assign dec_ext    = {{(W+1){1'b0}}, dec_sel};
  assign prod       = cur_ext * dec_ext;
  assign prod_shift = prod >>> FRAC;  // arithmetic shift: floor rounding
  assign upd_sum    = {prod_shift[2*W], prod_shift}
                    + {{(W+2){acc_sel[W-1]}}, acc_sel};
  assign upd_val    = sat_w(upd_sum);

  // --------------------------------------------------------------------------
  // Per-channel storage
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [W-1:0]         acc_reg;
    logic [W-1:0]         cur_reg;
    logic                 proc;
    logic                 hit;
    logic [W-1:0]         acc_base;
    logic signed [SW-1:0] acc_sum;

    assign proc = (state == S_RUN) && (ch == CW'(gi));
    assign hit  = wr_en && (wr_ch == CW'(gi));

    // A write that lands on the cycle this channel is processed starts the
    // next step's accumulation. The current update still uses the old acc.
    assign acc_base = proc ? '0 : acc_reg;
    assign acc_sum  = {{(W+2){acc_base[W-1]}}, acc_base}
                    + {{(W+2){wr_data[W-1]}}, wr_data};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_reg <= '0;
        cur_reg <= '0;
      end else begin
        if (hit)
          acc_reg <= sat_w(acc_sum);
        else if (proc)
          acc_reg <= '0;
        if (proc)
          cur_reg <= upd_val;
      end
    end

`ifdef DECAY_PER_CH_EN
    logic [W-1:0] dec_reg;
    // A cfg write takes effect from the next read of dec_reg.
    // A same-cycle update of this channel therefore still uses the old factor.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        dec_reg <= DEC_ONE;
      else if (cfg_en && (cfg_ch == CW'(gi)))
        dec_reg <= cfg_decay;
    end
    assign dec_vec[gi] = dec_reg;
`endif

    assign acc_vec[gi]         = acc_reg;
    assign cur_vec[gi]         = cur_reg;
    assign i_out[gi*W +: W]    = cur_reg;
  end

  // --------------------------------------------------------------------------
  // Step sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ch           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      step_overrun <= 1'b0;
    end else begin
      if (step_req && (state != S_IDLE))
        step_overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (step_req) begin
            state <= S_RUN;
            ch    <= '0;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (ch == CW'(NCH-1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ch <= ch + CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
